// File: rtl/simd_alu_sequencer.sv
// simd_alu_sequencer
//   Issue/writeback controller for one SIMD core. It accepts a decoded ALU
//   instruction and reads per-lane operands from its register file. It then
//   drives NUM_LANES ALU lanes for one execute cycle and writes each enabled
//   lane's result back to rd. A host port loads and inspects the registers.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   instr_valid/ready : instruction handshake
//   instr_op/rd/rs1/rs2/mask : decoded instruction fields
//   alu_enable, simd_state, alu_op, alu_rm, alu_rn : drive to the ALU lanes
//   alu_out           : lane results, valid the cycle after execute
//   done, div_zero    : one-cycle retire pulse, per-lane divide-by-zero flags
//   host_we/lane/addr/wdata, host_rdata : host register access

`ifndef ALU_ADD
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_MUL 3'd2
`define ALU_DIV 3'd3
`define ALU_AND 3'd4
`define ALU_OR  3'd5
`endif
`ifndef SIMD_EXECUTE
`define SIMD_EXECUTE 3'd2
`endif

module simd_alu_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_LANES  = 4,
  parameter int NUM_REGS   = 16,
  parameter int REG_AW     = 4,
  parameter int LANE_AW    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            instr_valid,
  output logic                            instr_ready,
  input  logic [2:0]                      instr_op,
  input  logic [REG_AW-1:0]               instr_rd,
  input  logic [REG_AW-1:0]               instr_rs1,
  input  logic [REG_AW-1:0]               instr_rs2,
  input  logic [NUM_LANES-1:0]            instr_mask,
  output logic [NUM_LANES-1:0]            alu_enable,
  output logic [2:0]                      simd_state,
  output logic [2:0]                      alu_op,
  output logic [NUM_LANES*DATA_WIDTH-1:0] alu_rm,
  output logic [NUM_LANES*DATA_WIDTH-1:0] alu_rn,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] alu_out,
  output logic                            done,
  output logic [NUM_LANES-1:0]            div_zero,
  input  logic                            host_we,
  input  logic [LANE_AW-1:0]              host_lane,
  input  logic [REG_AW-1:0]               host_addr,
  input  logic [DATA_WIDTH-1:0]           host_wdata,
  output logic [DATA_WIDTH-1:0]           host_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t                            state_q, state_d;
  logic [2:0]                        op_q, op_d;
  logic [REG_AW-1:0]                 rd_q, rd_d;
  logic [REG_AW-1:0]                 rs1_q, rs1_d;
  logic [REG_AW-1:0]                 rs2_q, rs2_d;
  logic [NUM_LANES-1:0]              mask_q, mask_d;
  logic [NUM_LANES*DATA_WIDTH-1:0]   alu_rm_q, alu_rm_d;
  logic [NUM_LANES*DATA_WIDTH-1:0]   alu_rn_q, alu_rn_d;
  logic [2:0]                        alu_op_q, alu_op_d;
  logic                              done_q, done_d;
  logic [NUM_LANES-1:0]              div_zero_q, div_zero_d;
  logic [DATA_WIDTH-1:0]             regs_q [NUM_LANES][NUM_REGS];
  logic [DATA_WIDTH-1:0]             regs_d [NUM_LANES][NUM_REGS];

  // A divide by zero retires as all-ones regardless of what the lane produced.
  function automatic logic [DATA_WIDTH-1:0] wb_value(
    input logic [2:0]            op,
    input logic [DATA_WIDTH-1:0] rn,
    input logic [DATA_WIDTH-1:0] res
  );
    if (op == `ALU_DIV && rn == '0) return '1;
    return res;
  endfunction

  function automatic logic is_div_zero(
    input logic [2:0]            op,
    input logic [DATA_WIDTH-1:0] rn
  );
    return (op == `ALU_DIV) && (rn == '0);
  endfunction

  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign alu_enable  = (state_q == S_EXEC && !rst) ? mask_q : '0;
  assign simd_state  = (state_q == S_EXEC && !rst) ? `SIMD_EXECUTE : (`SIMD_EXECUTE ^ 3'd1);
  assign alu_op      = alu_op_q;
  assign alu_rm      = alu_rm_q;
  assign alu_rn      = alu_rn_q;
  assign done        = done_q;
  assign div_zero    = div_zero_q;
  // r0 is never written, so it always reads back as its reset value of 0.
  assign host_rdata  = regs_q[host_lane][host_addr];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    mask_d     = mask_q;
    alu_rm_d   = alu_rm_q;
    alu_rn_d   = alu_rn_q;
    alu_op_d   = alu_op_q;
    done_d     = 1'b0;
    div_zero_d = '0;
    regs_d     = regs_q;

    case (state_q)
      // Stage IDLE: host access and instruction accept
      S_IDLE: begin
        if (host_we && host_addr != '0) regs_d[host_lane][host_addr] = host_wdata;
        if (instr_valid && instr_ready) begin
          op_d    = instr_op;
          rd_d    = instr_rd;
          rs1_d   = instr_rs1;
          rs2_d   = instr_rs2;
          mask_d  = instr_mask;
          state_d = S_READ;
        end
      end
      // Stage READ: operand fetch into the lane operand registers
      S_READ: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          alu_rm_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i][rs1_q];
          alu_rn_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i][rs2_q];
        end
        alu_op_d = op_q;
        state_d  = S_EXEC;
      end
      // Stage EXEC: lanes enabled for exactly one cycle
      S_EXEC: begin
        state_d = S_WB;
      end
      // Stage WB: result writeback and retire
      S_WB: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (mask_q[i]) begin
            div_zero_d[i] = is_div_zero(op_q, alu_rn_q[i*DATA_WIDTH +: DATA_WIDTH]);
            if (rd_q != '0)
              regs_d[i][rd_q] = wb_value(op_q, alu_rn_q[i*DATA_WIDTH +: DATA_WIDTH],
                                         alu_out[i*DATA_WIDTH +: DATA_WIDTH]);
          end
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      mask_q     <= '0;
      alu_rm_q   <= '0;
      alu_rn_q   <= '0;
      alu_op_q   <= '0;
      done_q     <= 1'b0;
      div_zero_q <= '0;
      for (int l = 0; l < NUM_LANES; l++)
        for (int r = 0; r < NUM_REGS; r++)
          regs_q[l][r] <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      mask_q     <= mask_d;
      alu_rm_q   <= alu_rm_d;
      alu_rn_q   <= alu_rn_d;
      alu_op_q   <= alu_op_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_simd_alu_sequencer.sv
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_MUL 3'd2
`define ALU_DIV 3'd3
`define ALU_AND 3'd4
`define ALU_OR  3'd5
`endif
`ifndef SIMD_EXECUTE
`define SIMD_EXECUTE 3'd2
`endif

module tb_simd_alu_sequencer;
  localparam int DW = 64;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [3:0]    instr_rd, instr_rs1, instr_rs2;
  logic [NL-1:0] instr_mask;
  logic [NL-1:0] alu_enable;
  logic [2:0]    simd_state;
  logic [2:0]    alu_op;
  logic [NL*DW-1:0] alu_rm, alu_rn;
  logic [NL*DW-1:0] alu_out = '0;
  logic          done;
  logic [NL-1:0] div_zero;
  logic          host_we;
  logic [1:0]    host_lane;
  logic [3:0]    host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] IDLE_ST = `SIMD_EXECUTE ^ 3'd1;

  simd_alu_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_mask(instr_mask),
    .alu_enable(alu_enable), .simd_state(simd_state), .alu_op(alu_op),
    .alu_rm(alu_rm), .alu_rn(alu_rn), .alu_out(alu_out),
    .done(done), .div_zero(div_zero),
    .host_we(host_we), .host_lane(host_lane), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  // Reference ALU lanes: latch a result at the end of an enabled execute cycle.
  function automatic logic [DW-1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      `ALU_ADD: return a + b;
      `ALU_SUB: return a - b;
      `ALU_MUL: return a * b;
      `ALU_DIV: return (b == '0) ? '0 : a / b;
      `ALU_AND: return a & b;
      `ALU_OR:  return a | b;
      default:  return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NL; i++)
      if (simd_state == `SIMD_EXECUTE && alu_enable[i])
        alu_out[i*DW +: DW] <= alu_fn(alu_op, alu_rm[i*DW +: DW], alu_rn[i*DW +: DW]);
  end

  task automatic host_write(input logic [1:0] lane, input logic [3:0] addr, input logic [DW-1:0] data);
    host_we = 1'b1; host_lane = lane; host_addr = addr; host_wdata = data;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] lane, input logic [3:0] addr, output logic [DW-1:0] data);
    host_lane = lane; host_addr = addr;
    #1 data = host_rdata;
  endtask

  // Issues one instruction at a negedge in IDLE and waits (bounded) for done.
  task automatic run_instr(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input logic [NL-1:0] mask,
                           output int lat, output logic [NL-1:0] en_x, output logic [2:0] st_x,
                           output logic [NL-1:0] dz);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_mask = mask;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    lat = -1; en_x = '0; st_x = '0; dz = '0;
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 2) begin en_x = alu_enable; st_x = simd_state; end
      if (done) begin lat = n; dz = div_zero; end
    end
  endtask

  task automatic test_reset;
    logic [DW-1:0] v;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%0b exp=0", instr_ready); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", instr_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (alu_enable !== 4'b0) begin bad++; $display("FAIL reset_enable got=%b exp=0000", alu_enable); end
    total++; if (simd_state !== IDLE_ST) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", simd_state, IDLE_ST); end
    total++; if (alu_rm !== '0 || alu_rn !== '0 || alu_op !== 3'd0) begin bad++; $display("FAIL reset_operands rm=%h rn=%h op=%0d exp=0", alu_rm, alu_rn, alu_op); end
    total++; if (div_zero !== 4'b0) begin bad++; $display("FAIL reset_divzero got=%b exp=0000", div_zero); end
    host_read(2'd2, 4'd5, v);
    total++; if (v !== 64'd0) begin bad++; $display("FAIL reset_reg got=%h exp=0", v); end
  endtask

  task automatic test_add;
    int lat; logic [NL-1:0] en, dz; logic [2:0] st; logic [DW-1:0] v;
    host_write(2'd0, 4'd1, 64'd5);
    host_write(2'd0, 4'd2, 64'd3);
    run_instr(`ALU_ADD, 4'd3, 4'd1, 4'd2, 4'b0001, lat, en, st, dz);
    total++; if (lat !== 4) begin bad++; $display("FAIL add_latency got=%0d exp=4", lat); end
    total++; if (en !== 4'b0001) begin bad++; $display("FAIL add_exec_enable got=%b exp=0001", en); end
    total++; if (st !== `SIMD_EXECUTE) begin bad++; $display("FAIL add_exec_state got=%0d exp=%0d", st, `SIMD_EXECUTE); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL add_ready_at_done got=%0b exp=1", instr_ready); end
    host_read(2'd0, 4'd3, v);
    total++; if (v !== 64'd8) begin bad++; $display("FAIL add_lane0_r3 got=%0d exp=8", v); end
    host_read(2'd1, 4'd3, v);
    total++; if (v !== 64'd0) begin bad++; $display("FAIL add_lane1_r3 got=%0d exp=0", v); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_one_cycle got=%0b exp=0", done); end
  endtask

  task automatic test_div_zero;
    int lat; logic [NL-1:0] en, dz; logic [2:0] st; logic [DW-1:0] v;
    for (int l = 0; l < NL; l++) begin
      host_write(l[1:0], 4'd1, 64'd10);
      host_write(l[1:0], 4'd2, 64'd0);
    end
    run_instr(`ALU_DIV, 4'd4, 4'd1, 4'd2, 4'b1111, lat, en, st, dz);
    total++; if (lat !== 4) begin bad++; $display("FAIL div_latency got=%0d exp=4", lat); end
    total++; if (dz !== 4'b1111) begin bad++; $display("FAIL div_zero_flags got=%b exp=1111", dz); end
    total++; if (alu_rm[2*DW +: DW] !== 64'd10) begin bad++; $display("FAIL div_rm_lane2 got=%0d exp=10", alu_rm[2*DW +: DW]); end
    for (int l = 0; l < NL; l++) begin
      host_read(l[1:0], 4'd4, v);
      total++; if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL div_r4_lane%0d got=%h exp=ffffffffffffffff", l, v); end
    end
  endtask

  task automatic test_rd_zero;
    int lat; logic [NL-1:0] en, dz; logic [2:0] st; logic [DW-1:0] v;
    run_instr(`ALU_SUB, 4'd0, 4'd1, 4'd2, 4'b1111, lat, en, st, dz);
    total++; if (lat !== 4) begin bad++; $display("FAIL rd0_latency got=%0d exp=4", lat); end
    total++; if (dz !== 4'b0000) begin bad++; $display("FAIL rd0_divzero got=%b exp=0000", dz); end
    host_read(2'd3, 4'd0, v);
    total++; if (v !== 64'd0) begin bad++; $display("FAIL rd0_r0 got=%0d exp=0", v); end
    host_read(2'd1, 4'd1, v);
    total++; if (v !== 64'd10) begin bad++; $display("FAIL rd0_r1_kept got=%0d exp=10", v); end
    host_read(2'd1, 4'd4, v);
    total++; if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rd0_r4_kept got=%h exp=ffffffffffffffff", v); end
    host_write(2'd0, 4'd0, 64'd77);
    host_read(2'd0, 4'd0, v);
    total++; if (v !== 64'd0) begin bad++; $display("FAIL host_r0_write got=%0d exp=0", v); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2; logic [DW-1:0] v; logic rdy;
    for (int l = 0; l < NL; l++) begin
      host_write(l[1:0], 4'd1, 64'd7);
      host_write(l[1:0], 4'd2, 64'd6);
    end
    instr_op = `ALU_MUL; instr_rd = 4'd5; instr_rs1 = 4'd1; instr_rs2 = 4'd2; instr_mask = 4'b1111;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_op = `ALU_ADD; instr_rd = 4'd6; instr_rs1 = 4'd5; instr_rs2 = 4'd1;
    lat1 = -1; rdy = 1'b0;
    for (int n = 1; n <= 10 && lat1 < 0; n++) begin
      if (n > 1) @(negedge clk);
      if (done) begin lat1 = n; rdy = instr_ready; end
    end
    total++; if (lat1 !== 4) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=4", lat1); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL b2b_ready_with_done got=%0b exp=1", rdy); end
    lat2 = -1;
    for (int n = 1; n <= 10 && lat2 < 0; n++) begin
      @(negedge clk);
      if (n == 1) instr_valid = 1'b0;
      if (done) lat2 = n;
    end
    instr_valid = 1'b0;
    total++; if (lat2 !== 4) begin bad++; $display("FAIL b2b_spacing got=%0d exp=4", lat2); end
    host_read(2'd2, 4'd5, v);
    total++; if (v !== 64'd42) begin bad++; $display("FAIL b2b_r5 got=%0d exp=42", v); end
    host_read(2'd2, 4'd6, v);
    total++; if (v !== 64'd49) begin bad++; $display("FAIL b2b_r6 got=%0d exp=49", v); end
  endtask

  task automatic test_undef_op;
    int lat; logic [NL-1:0] en, dz; logic [2:0] st; logic [DW-1:0] v;
    host_write(2'd0, 4'd9, 64'd5);
    run_instr(3'd6, 4'd9, 4'd1, 4'd2, 4'b0001, lat, en, st, dz);
    host_read(2'd0, 4'd9, v);
    total++; if (v !== 64'd0) begin bad++; $display("FAIL undef_op_r9 got=%0d exp=0", v); end
  endtask

  task automatic test_reset_abort;
    logic [DW-1:0] v; logic seen_done;
    instr_op = `ALU_ADD; instr_rd = 4'd7; instr_rs1 = 4'd1; instr_rs2 = 4'd2; instr_mask = 4'b1111;
    instr_valid = 1'b1;
    @(negedge clk);            // accepted, now READ
    instr_valid = 1'b0;
    @(negedge clk);            // EXEC
    rst = 1'b1;
    #1;
    total++; if (alu_enable !== 4'b0) begin bad++; $display("FAIL abort_enable_in_rst got=%b exp=0000", alu_enable); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%0b exp=1", instr_ready); end
    seen_done = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%0b exp=0", seen_done); end
    host_read(2'd1, 4'd7, v);
    total++; if (v !== 64'd0) begin bad++; $display("FAIL abort_r7 got=%0d exp=0", v); end
    host_read(2'd1, 4'd5, v);
    total++; if (v !== 64'd0) begin bad++; $display("FAIL abort_r5_cleared got=%0d exp=0", v); end
  endtask

  task automatic test_host_gate;
    int lat; logic [DW-1:0] v; logic [NL-1:0] dz;
    instr_op = `ALU_ADD; instr_rd = 4'd8; instr_rs1 = 4'd1; instr_rs2 = 4'd2; instr_mask = 4'b0000;
    instr_valid = 1'b1;
    @(negedge clk);            // READ
    instr_valid = 1'b0;
    @(negedge clk);            // EXEC
    host_write(2'd0, 4'd1, 64'd99);
    lat = -1; dz = '1;
    for (int n = 3; n <= 10 && lat < 0; n++) begin
      if (done) begin lat = n; dz = div_zero; end
      else @(negedge clk);
    end
    total++; if (lat !== 4) begin bad++; $display("FAIL mask0_latency got=%0d exp=4", lat); end
    total++; if (dz !== 4'b0) begin bad++; $display("FAIL mask0_divzero got=%b exp=0000", dz); end
    host_read(2'd0, 4'd1, v);
    total++; if (v !== 64'd0) begin bad++; $display("FAIL host_exec_ignored got=%0d exp=0", v); end
    host_read(2'd0, 4'd8, v);
    total++; if (v !== 64'd0) begin bad++; $display("FAIL mask0_r8 got=%0d exp=0", v); end
    @(negedge clk);
    host_write(2'd0, 4'd1, 64'd99);
    host_read(2'd0, 4'd1, v);
    total++; if (v !== 64'd99) begin bad++; $display("FAIL host_idle_write got=%0d exp=99", v); end
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0;
    instr_rs2 = '0; instr_mask = '0; host_we = 1'b0; host_lane = '0; host_addr = '0;
    host_wdata = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_div_zero();
    test_rd_zero();
    test_back_to_back();
    test_undef_op();
    test_reset_abort();
    test_host_gate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/simd_alu_sequencer.md
Name: simd_alu_sequencer

Overview:
- Issue/writeback controller for one SIMD core; the driving end of the per-lane ALU interface.
- Accepts a decoded ALU instruction, reads per-lane operands from its internal register file, and drives rm/rn/alu_op/simd_state/enable to NUM_LANES ALU lanes.
- Captures each lane's alu_out one cycle later and writes it back to rd.
- A host port loads and inspects registers.

Parameters:
- DATA_WIDTH, 64, lane datapath width (matches ALU).
- NUM_LANES, 4, ALU lanes driven.
- NUM_REGS, 16, registers per lane.
- REG_AW, 4, register address width, log2(NUM_REGS).
- LANE_AW, 2, lane index width, log2(NUM_LANES).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset: synchronous, active-high.
- instr_valid, input, 1, instruction offered.
- instr_ready, output, 1, sequencer can accept an instruction.
- instr_op, input, 3, ALU opcode (`ALU_* encodings).
- instr_rd / instr_rs1 / instr_rs2, input, REG_AW each, destination / first source / second source register.
- instr_mask, input, NUM_LANES, lane enable mask.
- alu_enable, output, NUM_LANES, per-lane ALU enable.
- simd_state, output, 3, state presented to the ALUs.
- alu_op, output, 3, opcode to all lanes.
- alu_rm, output, NUM_LANES*DATA_WIDTH, rs1 operand; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- alu_rn, output, NUM_LANES*DATA_WIDTH, rs2 operand, same packing.
- alu_out, input, NUM_LANES*DATA_WIDTH, lane results, same packing.
- done, output, 1, one-cycle pulse: instruction retired.
- div_zero, output, NUM_LANES, valid with done: lane hit DIV with rn==0.
- host_we, input, 1, host register write strobe.
- host_lane, input, LANE_AW, host lane select.
- host_addr, input, REG_AW, host register select.
- host_wdata, input, DATA_WIDTH, host write data.
- host_rdata, output, DATA_WIDTH, combinational read of regs[host_lane][host_addr].

Behaviour:
- Register file: NUM_LANES x NUM_REGS x DATA_WIDTH. Register 0 reads 0 in every lane; writes to it are discarded (host and writeback).
- FSM has four states: IDLE, READ, EXEC, WB.
- IDLE:
  - instr_ready = 1 (0 while rst high).
  - On instr_valid && instr_ready, latch op/rd/rs1/rs2/mask and go to READ.
- READ:
  - Register alu_rm/alu_rn per lane from regs[lane][rs1] and regs[lane][rs2].
  - Drive alu_op = latched op; go to EXEC.
- EXEC:
  - simd_state = `SIMD_EXECUTE and alu_enable = latched mask, for exactly this cycle.
  - ALUs latch their results at the end of this cycle. Go to WB.
- WB:
  - For each lane with mask=1 and rd!=0, write alu_out lane into regs[lane][rd] at the end of the cycle.
  - Override: if op==`ALU_DIV and that lane's rn==0, write all-ones and set div_zero[lane].
  - Go to IDLE; done=1 and div_zero are valid in the next cycle only.
- Outside EXEC:
  - simd_state = (`SIMD_EXECUTE ^ 3'd1).
  - alu_enable = 0.
  - alu_rm/alu_rn/alu_op hold their last values.
- Latency: accept at edge k -> READ k+1, EXEC k+2, WB k+3, done and updated register visible on host_rdata at k+4.
  - instr_ready is high again in that same cycle; a new instruction may be accepted while done=1.
  - Throughput is 1 instruction per 4 cycles.
- Masked-off lanes: no ALU enable, no writeback, div_zero bit 0. A mask of all zeros still takes 4 cycles and pulses done.
- Undefined opcodes (6,7): pass alu_out (0 from the ALU) through to the register file unchanged.
- Hazard: rd equal to rs1/rs2 of the next instruction needs no stall; writeback completes before the next READ.
- Host port:
  - host_we honoured only in IDLE (including the accept cycle); ignored in READ/EXEC/WB.
  - A host write in the accept cycle is visible to that instruction's READ.
- Reset:
  - FSM -> IDLE; all registers, alu_rm, alu_rn, alu_op, div_zero cleared to 0; done=0; alu_enable=0; simd_state=(`SIMD_EXECUTE ^ 3'd1).
  - Reset during READ/EXEC/WB aborts the instruction: no writeback, no done.

Test Plan:
- Host writes lane0 r1=5, r2=3; issue ADD rd=3 mask=4'b0001 -> done 4 cycles after accept, lane0 r3=8, lane1 r3 unchanged (0).
- All lanes r1=10, r2=0; issue DIV rd=4 mask=4'b1111 -> all lanes r4=64'hFFFF_FFFF_FFFF_FFFF, div_zero=4'b1111 with done.
- Issue SUB rd=0 -> done pulses, r0 still reads 0, no lane register changes.
- Back-to-back: MUL r5=r1*r2 (7*6), then ADD r6=r5+r1 held valid continuously -> second accepted in the cycle done=1, r6=49, accept spacing 4 cycles.
- Assert rst during EXEC of ADD rd=7 -> r7=0, done never pulses, instr_ready=1 the cycle after rst drops.
- host_we targeting r1 during EXEC -> write ignored; the same write in IDLE -> host_rdata shows the new value next cycle.
